// File: rtl/serial_mul_sat.sv
// Sequential shift-add multiplier: signed/unsigned operands, one multiplier bit per cycle,
// with a selectable wrap or saturate reduction to an N_BITS_RESULT-bit result.
module serial_mul_sat #(
  parameter int unsigned N_BITS_A      = 8,
  parameter int unsigned N_BITS_B      = 8,
  parameter int unsigned N_BITS_RESULT = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_BITS_A-1:0]      a,
  input  logic [N_BITS_B-1:0]      b,
  input  logic                     signed_mode,
  input  logic                     sat_mode,
  output logic [N_BITS_RESULT-1:0] result,
  output logic                     data_ready,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned ACC_W = N_BITS_A + N_BITS_B;
  localparam int unsigned CNT_W = $clog2(N_BITS_B);
  localparam int unsigned RES_W = N_BITS_RESULT;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS_B - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    a_sh_q, a_sh_d;
  logic [N_BITS_B-1:0] b_sh_q, b_sh_d;
  logic                sgn_q, sgn_d;
  logic                sat_q, sat_d;
  logic [RES_W-1:0]    result_d;
  logic                overflow_d;
  logic                busy_d;
  logic                data_ready_d;

  logic [ACC_W-1:0]    partial;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    hi_bits;
  logic                ovf_c;
  logic [RES_W-1:0]    sat_val;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sgn_q      <= 1'b0;
      sat_q      <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sgn_q      <= sgn_d;
      sat_q      <= sat_d;
      result     <= result_d;
      overflow   <= overflow_d;
      busy       <= busy_d;
      data_ready <= data_ready_d;
    end
  end

  // Next-state, shift-add step and final reduction
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sgn_d      = sgn_q;
    sat_d      = sat_q;
    result_d   = result;
    overflow_d = overflow;

    // The MSB partial product carries negative weight in two's complement
    partial = b_sh_q[0] ? a_sh_q : '0;
    acc_sum = (sgn_q && (cnt_q == LAST_CNT)) ? (acc_q - partial) : (acc_q + partial);

    hi_bits = $unsigned($signed(acc_sum) >>> (RES_W - 1));
    if (sgn_q) ovf_c = !((hi_bits == '0) || (hi_bits == '1));
    else       ovf_c = (acc_sum >> RES_W) != '0;

    if (!sgn_q)                  sat_val = '1;
    else if (acc_sum[ACC_W-1])   sat_val = {1'b1, {(RES_W-1){1'b0}}};
    else                         sat_val = {1'b0, {(RES_W-1){1'b1}}};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          a_sh_d  = signed_mode ? {{N_BITS_B{a[N_BITS_A-1]}}, a} : ACC_W'(a);
          b_sh_d  = b;
          sgn_d   = signed_mode;
          sat_d   = sat_mode;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d    = DONE;
          overflow_d = ovf_c;
          result_d   = (sat_q && ovf_c) ? sat_val : acc_sum[RES_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d == RUN);
    data_ready_d = (state_d == DONE);
  end

endmodule
